// File: rtl/dt_pkg.sv
// Shared constants, FSM state type and pixel threshold helper for the
// binary-image packer.
package dt_pkg;

  localparam int IMG_W   = 128;
  localparam int PIX_N   = 16384;
  localparam int WORD_N  = 1024;
  localparam int WORD_W  = 16;

  localparam int PIX_AW  = 14;
  localparam int WORD_AW = 10;
  localparam int CNT_W   = 15;

  localparam logic [PIX_AW-1:0] LAST_PIX = 14'd16383;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // A pixel is foreground whenever any of its bits is set.
  function automatic logic pix_on(input logic [7:0] pix);
    return (pix != 8'd0);
  endfunction

endpackage

// File: rtl/sti_bitpack.sv
// Threshold/shift/pack datapath: turns one pixel per capture into a bit and
// emits a full 16-bit word (first pixel in the MSB) every 16th capture.
module sti_bitpack
  import dt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               capture,
  input  logic [3:0]         bit_idx,
  input  logic [WORD_AW-1:0] word_idx,
  input  logic [7:0]         pix,
  output logic               pix_one,
  output logic               sti_wr,
  output logic [WORD_AW-1:0] sti_addr,
  output logic [WORD_W-1:0]  sti_do
);

  logic [WORD_W-2:0] pack;
  logic [WORD_W-1:0] word_next;
  logic              word_full;

  assign pix_one   = pix_on(pix);
  assign word_next = {pack, pix_one};
  assign word_full = capture && (bit_idx == 4'd15);

  // Shift register holding the first 15 bits of the word being assembled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack <= '0;
    end else if (capture) begin
      pack <= word_next[WORD_W-2:0];
    end else begin
      pack <= pack;
    end
  end

  // Registered write port: the completed word goes out on the 16th capture edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sti_wr   <= 1'b0;
      sti_addr <= '0;
      sti_do   <= '0;
    end else begin
      sti_wr <= word_full;
      if (word_full) begin
        sti_addr <= word_idx;
        sti_do   <= word_next;
      end else begin
        sti_addr <= sti_addr;
        sti_do   <= sti_do;
      end
    end
  end

endmodule

// File: rtl/sti_packer.sv
// Streams a 128x128 8-bit image out of pixel memory and writes it back as
// 1024 packed 16-bit binary words; also reports the foreground pixel count.
module sti_packer
  import dt_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               res_rd,
  output logic [PIX_AW-1:0]  res_addr,
  input  logic [7:0]         res_di,
  output logic               sti_wr,
  output logic [WORD_AW-1:0] sti_addr,
  output logic [WORD_W-1:0]  sti_do,
  output logic [CNT_W-1:0]   ones_cnt
);

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic              capture;
  logic              last_pix;
  logic              pix_one;
  logic [CNT_W-1:0]  ones_acc;

  assign accept   = (state == ST_IDLE) && start;
  // Data for the address driven last cycle arrives on every READ edge.
  assign capture  = (state == ST_READ);
  assign last_pix = (res_addr == LAST_PIX);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_READ;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_READ: begin
        if (last_pix) begin
          next_state = ST_FLUSH;
        end else begin
          next_state = ST_READ;
        end
      end
      ST_FLUSH: next_state = ST_FIN;
      ST_FIN:   next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Registered handshake outputs derived from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      res_rd <= 1'b0;
    end else begin
      busy   <= (next_state == ST_READ) || (next_state == ST_FLUSH);
      done   <= (next_state == ST_FIN);
      res_rd <= (next_state == ST_READ);
    end
  end

  // Pixel address: zero at start-accept, then one step per cycle, no stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_addr <= '0;
    end else if (accept) begin
      res_addr <= '0;
    end else if (capture && !last_pix) begin
      res_addr <= res_addr + 14'd1;
    end else begin
      res_addr <= res_addr;
    end
  end

  // Foreground accumulator; 15 bits so a full image (16384) does not wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_acc <= '0;
    end else if (accept) begin
      ones_acc <= '0;
    end else if (capture && pix_one) begin
      ones_acc <= ones_acc + 15'd1;
    end else begin
      ones_acc <= ones_acc;
    end
  end

  // Published count changes only on FIN entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_cnt <= '0;
    end else if (state == ST_FLUSH) begin
      ones_cnt <= ones_acc;
    end else begin
      ones_cnt <= ones_cnt;
    end
  end

  sti_bitpack u_bitpack (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .bit_idx  (res_addr[3:0]),
    .word_idx (res_addr[PIX_AW-1:4]),
    .pix      (res_di),
    .pix_one  (pix_one),
    .sti_wr   (sti_wr),
    .sti_addr (sti_addr),
    .sti_do   (sti_do)
  );

endmodule

// File: tb/tb_sti_packer.sv
// Scoreboard bench for sti_packer: a pixel-memory model feeds the DUT, expected
// words are queued per image and a monitor checks every sti_wr against them.
module tb_sti_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di = 8'd0;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic [14:0] ones_cnt;

  logic [7:0]  img [16384];
  bit          bin [16384];
  logic [25:0] exp_q [$];
  logic [25:0] mon_e;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int run_writes = 0;
  int exp_ones = 0;
  int dt_ones = 0;

  sti_packer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .sti_wr   (sti_wr),
    .sti_addr (sti_addr),
    .sti_do   (sti_do),
    .ones_cnt (ones_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memory: samples the address on the falling edge.
  always @(negedge clk) begin
    if (res_rd === 1'b1) res_di = img[res_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each write is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (sti_wr === 1'b1) begin
      run_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {22'd0, sti_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sti_addr", {22'd0, sti_addr}, {22'd0, mon_e[25:16]});
        chk("sti_do", {16'd0, sti_do}, {16'd0, mon_e[15:0]});
      end
    end
  end

  // Golden words from the binary image: pixel 16k+j -> word k, bit 15-j.
  task automatic push_expected(output int ones);
    logic [15:0] w;
    ones = 0;
    for (int k = 0; k < 1024; k++) begin
      w = 16'd0;
      for (int j = 0; j < 16; j++) begin
        if (bin[16*k + j]) begin
          w[15-j] = 1'b1;
          ones++;
        end
      end
      exp_q.push_back({10'(k), w});
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int p = 0; p < 16384; p++) begin
      img[p] = v;
      bin[p] = (v != 8'd0);
    end
  endtask

  task automatic fill_random();
    for (int p = 0; p < 16384; p++) begin
      img[p] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
      bin[p] = (img[p] != 8'd0);
    end
  endtask

  // Distance-transform style image: random rectangles, interior value is
  // 1 + distance to the rectangle border; bin[] is the original binary input.
  task automatic fill_dt();
    int r0[4], r1[4], c0[4], c1[4];
    int d;
    for (int i = 0; i < 4; i++) begin
      r0[i] = int'($urandom_range(0, 100));
      r1[i] = r0[i] + int'($urandom_range(4, 27));
      c0[i] = int'($urandom_range(0, 100));
      c1[i] = c0[i] + int'($urandom_range(4, 27));
    end
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 128; c++) begin
        img[r*128 + c] = 8'd0;
        bin[r*128 + c] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (!bin[r*128 + c] && r >= r0[i] && r <= r1[i] && c >= c0[i] && c <= c1[i]) begin
            d = r - r0[i];
            if (r1[i] - r < d) d = r1[i] - r;
            if (c - c0[i] < d) d = c - c0[i];
            if (c1[i] - c < d) d = c1[i] - c;
            img[r*128 + c] = 8'(d + 1);
            bin[r*128 + c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic run(input int ones_exp, input int prev_ones, input bit repulse);
    bit got;
    got = 1'b0;
    run_writes = 0;
    pulse_start();
    for (int i = 0; i < 17000 && !got; i++) begin
      @(negedge clk);
      start = repulse && (cyc - start_cyc == 100);
      if (cyc - start_cyc == 50) begin
        chk("busy_mid", {31'd0, busy}, 32'd1);
        chk("res_rd_mid", {31'd0, res_rd}, 32'd1);
        chk("ones_hold_mid", {17'd0, ones_cnt}, prev_ones);
      end
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("done_latency", cyc - start_cyc, 32'd16385);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("res_rd_at_done", {31'd0, res_rd}, 32'd0);
      chk("write_count", run_writes, 32'd1024);
      chk("ones_cnt", {17'd0, ones_cnt}, ones_exp);
      chk("queue_drained", exp_q.size(), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_res_rd"}, {31'd0, res_rd}, 32'd0);
    chk({tag, "_sti_wr"}, {31'd0, sti_wr}, 32'd0);
    chk({tag, "_res_addr"}, {18'd0, res_addr}, 32'd0);
    chk({tag, "_sti_addr"}, {22'd0, sti_addr}, 32'd0);
    chk({tag, "_sti_do"}, {16'd0, sti_do}, 32'd0);
    chk({tag, "_ones_cnt"}, {17'd0, ones_cnt}, 32'd0);
  endtask

  initial begin
    fill_const(8'd0);
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // All-zero image.
    fill_const(8'd0);
    push_expected(exp_ones);
    run(exp_ones, 0, 1'b0);
    @(negedge clk);
    chk("done_one_cycle_zero", {31'd0, done}, 32'd1 - 32'd1);

    // Random image aborted by reset 5000 cycles into the run.
    fill_random();
    push_expected(exp_ones);
    @(negedge clk);
    run_writes = 0;
    pulse_start();
    repeat (4999) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("abort");
    chk("abort_writes", run_writes, 32'd312);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", {30'd0, busy, res_rd}, 32'd0);

    // Distance-transform round trip, with a stray start mid-run.
    fill_dt();
    push_expected(dt_ones);
    run(dt_ones, 0, 1'b1);
    @(negedge clk);
    chk("done_one_cycle_dt", {31'd0, done}, 32'd0);

    // Back-to-back: all-ones image, then sparse image started right after done.
    fill_const(8'h01);
    push_expected(exp_ones);
    run(exp_ones, dt_ones, 1'b0);
    @(negedge clk);
    chk("done_one_cycle_ones", {31'd0, done}, 32'd0);
    fill_const(8'd0);
    img[0]  = 8'hFF;
    bin[0]  = 1'b1;
    img[31] = 8'h05;
    bin[31] = 1'b1;
    push_expected(exp_ones);
    chk("sparse_model_ones", exp_ones, 32'd2);
    run(exp_ones, 16384, 1'b0);
    @(negedge clk);
    chk("done_one_cycle_sparse", {31'd0, done}, 32'd0);
    chk("ones_hold_after", {17'd0, ones_cnt}, 32'd2);

    repeat (4) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sti_packer.md
STI_PACKER -- requirements
Module: sti_packer

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port: start  input  1  single-cycle request to pack one 128x128 image.
REQ-004 SHALL have port: busy  output  1  high from the start-accept edge until the done pulse.
REQ-005 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-006 SHALL have port: res_rd  output  1  pixel-memory read enable; memory samples on falling edge.
REQ-007 SHALL have port: res_addr  output  14  pixel address 0..16383, row-major.
REQ-008 SHALL have port: res_di  input  8  pixel data, valid at the rising edge after the address was driven.
REQ-009 SHALL have port: sti_wr  output  1  packed-word write enable; memory writes on rising edge.
REQ-010 SHALL have port: sti_addr  output  10  word address 0..1023.
REQ-011 SHALL have port: sti_do  output  16  packed binary word.
REQ-012 SHALL have port: ones_cnt  output  15  count of nonzero pixels in the last completed image, 0..16384.
REQ-013 SHALL use one clock and an asynchronous active-high reset, as fixed for this block.

Function
REQ-014 SHALL perform the inverse of the binary-image read path: each 8-bit pixel maps to one bit (1 if nonzero, 0 if zero); 16 consecutive pixels pack into one 16-bit word.
REQ-015 SHALL map pixel p = 16k+j to sti word k, bit 15-j (MSB = first pixel).
REQ-016 SHALL implement the FSM states IDLE, READ, FLUSH, FIN.
- IDLE -> READ on start=1.
- READ -> FLUSH after address 16383 is issued.
- FLUSH -> FIN after one cycle.
- FIN -> IDLE after one cycle.
REQ-017 SHALL, at the edge accepting start in IDLE, drive res_rd=1 and res_addr=0, then increment res_addr by 1 every cycle (no stalls) through 16383.
REQ-018 SHALL capture res_di at each rising edge one cycle after the corresponding address was driven (1-cycle read latency), shifting the thresholded bit into the pack register.
REQ-019 SHALL, at the edge capturing pixel j=15 of word k, assert sti_wr=1 with sti_addr=k and sti_do equal to the complete word for exactly one cycle; sti_wr SHALL be 0 otherwise.
REQ-020 SHALL deassert res_rd in FLUSH, FIN and IDLE; the final capture (pixel 16383) and write of word 1023 occur at the FLUSH-entry edge.
REQ-021 SHALL assert done for exactly one cycle in FIN, 16385 cycles after the start-accept edge; busy SHALL fall at the same edge done rises.
REQ-022 SHALL accumulate nonzero pixels in an internal counter cleared at start-accept, and SHALL copy it to ones_cnt at FIN entry; ones_cnt SHALL hold its value until the next FIN.
REQ-023 SHALL ignore start while busy=1, and SHALL ignore start in FIN.
REQ-024 SHALL use 15-bit arithmetic for the counter; the value 16384 SHALL be representable without wrap.

Reset
REQ-025 SHALL, on reset=1, immediately set the following, with no partial write issued: state=IDLE; busy, done, res_rd, sti_wr = 0; res_addr, sti_addr, sti_do, ones_cnt = 0; pack register and counter = 0.
REQ-026 SHALL treat reset mid-operation as abort; the next start SHALL restart from pixel 0.

Structure
REQ-027 SHALL place the following in shared package dt_pkg:
- IMG_W=128, PIX_N=16384, WORD_N=1024, WORD_W=16.
- FSM state typedef.
REQ-028 SHALL place the shift/threshold/packing datapath in one sub-module sti_bitpack; the FSM, address counter and ones counter SHALL stay in sti_packer.

Verification
REQ-029 All-zero pixel memory, start pulse -> 1024 writes of 16'h0000 to addresses 0..1023; ones_cnt=0; done exactly 16385 cycles after the start edge.
REQ-030 All pixels 8'h01 -> every word 16'hFFFF; ones_cnt=16384.
REQ-031 Only pixel 0 = 8'hFF, pixel 31 = 8'h05 -> word0=16'h8000, word1=16'h0001, all other words 0; ones_cnt=2.
REQ-032 Round trip: pack a golden distance-transform result image and compare the 1024 words to the golden binary input image -> zero mismatches.
REQ-033 start re-pulsed at cycle 100 of a run -> no restart, sequence unchanged; reset asserted at cycle 5000 -> outputs 0 immediately, no sti_wr; fresh start -> correct full image.
REQ-034 Back-to-back runs: start asserted the cycle after done -> accepted; second image results correct; ones_cnt updates only at the second FIN.
